// File: rtl/cfg_update_scheduler_pkg.sv
// Shared constants and types for the configuration update scheduler.
package cfg_pkg;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;
  localparam int NUM_CFG_REGS = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Only the five configuration registers at the bottom of the map exist.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_PWM_DUTY;
  endfunction
endpackage

// File: rtl/cfg_update_scheduler_if.sv
// Write-request bus for the two requesters (SPI decoder and sequencer).
interface cfg_update_scheduler_if;
  logic                       req0_valid;
  logic                       req0_ready;
  logic [cfg_pkg::ADDR_W-1:0] req0_addr;
  logic [cfg_pkg::DATA_W-1:0] req0_data;
  logic                       req1_valid;
  logic                       req1_ready;
  logic [cfg_pkg::ADDR_W-1:0] req1_addr;
  logic [cfg_pkg::DATA_W-1:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/cfg_update_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; pointer moves to the other input after a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;

  // Grant a lone requester directly; on contention grant the pointer's side.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o[ptr_q] = 1'b1;
      else                gnt_o = req_i;
    end
  end

  // Favour the input that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cfg_update_scheduler.sv
// Arbitrates config writes into shadow registers and commits them to the
// active outputs only at a PWM period boundary or on timeout.
module cfg_update_scheduler
  import cfg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cfg_update_scheduler_if.slave req_if,
  input  logic                  commit_stb_i,
  output logic [DATA_W-1:0]     en_reg_out_7_0_o,
  output logic [DATA_W-1:0]     en_reg_out_15_8_o,
  output logic [DATA_W-1:0]     en_reg_pwm_7_0_o,
  output logic [DATA_W-1:0]     en_reg_pwm_15_8_o,
  output logic [DATA_W-1:0]     pwm_duty_cycle_o,
  output logic                  pending_o,
  output logic                  addr_err_o
);
  localparam int          TMO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [15:0] TMO_LAST   = TMO_LAST_I[15:0];

  state_e              state_q, state_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]   shadow_q [NUM_CFG_REGS];
  logic [DATA_W-1:0]   active_q [NUM_CFG_REGS];
  logic                addr_err_q;
  logic [1:0]          gnt;
  logic                wr_fire, wr_ok, timeout_hit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req_if.req1_valid, req_if.req0_valid}),
    .en_i  (state_q != COMMIT),
    .gnt_o (gnt)
  );

  assign req_if.req0_ready = gnt[0];
  assign req_if.req1_ready = gnt[1];

  // Route the granted requester's address/data to the shadow write port.
  always_comb begin
    wr_addr = gnt[1] ? req_if.req1_addr : req_if.req0_addr;
    wr_data = gnt[1] ? req_if.req1_data : req_if.req0_data;
    wr_fire = |gnt;
    wr_ok   = wr_fire && addr_valid(wr_addr);
  end

  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

  // Next-state and timeout counter: only valid writes open a pending window.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          state_d   = PENDING;
          tmo_cnt_d = 16'd0;
        end
      end
      PENDING: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (commit_stb_i || timeout_hit) state_d = COMMIT;
      end
      COMMIT: begin
        state_d   = IDLE;
        tmo_cnt_d = 16'd0;
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = 16'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_cnt_q  <= 16'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      addr_err_q <= wr_fire && !addr_valid(wr_addr);
    end
  end

  // Shadow bank: last accepted write to an address wins until commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) shadow_q[i] <= '0;
    end else if (wr_ok) begin
      shadow_q[wr_addr[2:0]] <= wr_data;
    end
  end

  // Active bank: whole shadow copied in the single COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) active_q[i] <= '0;
    end else if (state_q == COMMIT) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) active_q[i] <= shadow_q[i];
    end
  end

  assign en_reg_out_7_0_o  = active_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8_o = active_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0_o  = active_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8_o = active_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle_o  = active_q[ADDR_PWM_DUTY[2:0]];
  assign pending_o         = (state_q != IDLE);
  assign addr_err_o        = addr_err_q;
endmodule

// File: tb/tb_cfg_update_scheduler.sv
// Bench for cfg_update_scheduler: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_cfg_update_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic commit_stb = 1'b0;
  logic commit8 = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cfg_update_scheduler_if bus ();
  cfg_update_scheduler_if bus8 ();

  logic [7:0] obs [5];
  logic       o_pend, o_err;
  logic [7:0] obs8 [5];
  logic       t8_pend, t8_err;

  cfg_update_scheduler #(.TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_if(bus), .commit_stb_i(commit_stb),
    .en_reg_out_7_0_o(obs[0]), .en_reg_out_15_8_o(obs[1]),
    .en_reg_pwm_7_0_o(obs[2]), .en_reg_pwm_15_8_o(obs[3]),
    .pwm_duty_cycle_o(obs[4]), .pending_o(o_pend), .addr_err_o(o_err)
  );

  cfg_update_scheduler #(.TIMEOUT(8)) dut_t8 (
    .clk(clk), .rst_n(rst_n), .req_if(bus8), .commit_stb_i(commit8),
    .en_reg_out_7_0_o(obs8[0]), .en_reg_out_15_8_o(obs8[1]),
    .en_reg_pwm_7_0_o(obs8[2]), .en_reg_pwm_15_8_o(obs8[3]),
    .pwm_duty_cycle_o(obs8[4]), .pending_o(t8_pend), .addr_err_o(t8_err)
  );

  // Reference model: shadow/active banks, whether uncommitted data exists,
  // whether the next cycle is the commit cycle, age of the pending window.
  localparam int T_MAIN = 1024;
  logic [7:0] m_shadow [5];
  logic [7:0] m_active [5];
  bit m_pend, m_commit, m_err;
  int m_age, m_last;
  bit exp_r0, exp_r1;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
    m_pend = 0; m_commit = 0; m_err = 0; m_age = 0; m_last = 1;
  endtask

  task automatic predict();
    exp_r0 = 0; exp_r1 = 0;
    if (!m_commit) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (m_last == 1) exp_r0 = 1; else exp_r1 = 1;
      end else begin
        exp_r0 = bus.req0_valid; exp_r1 = bus.req1_valid;
      end
    end
  endtask

  // Apply one clock edge to the model and the DUTs; returns at posedge+1.
  task automatic advance();
    int a;
    logic [7:0] d;
    bit was_pend;
    predict();
    was_pend = m_pend;
    m_err = 0;
    if (m_commit) begin
      for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
      m_commit = 0;
    end else begin
      if (exp_r0 || exp_r1) begin
        a = exp_r0 ? int'(bus.req0_addr) : int'(bus.req1_addr);
        d = exp_r0 ? bus.req0_data : bus.req1_data;
        m_last = exp_r0 ? 0 : 1;
        if (a < 5) begin
          m_shadow[a] = d;
          if (!was_pend) begin m_pend = 1; m_age = 0; end
        end else m_err = 1;
      end
      if (was_pend) begin
        if (commit_stb || (m_age == T_MAIN - 1)) begin m_pend = 0; m_commit = 1; end
        else m_age++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    bus8.req0_valid = 0; bus8.req0_addr = '0; bus8.req0_data = '0;
    bus8.req1_valid = 0; bus8.req1_addr = '0; bus8.req1_data = '0;
    commit_stb = 0; commit8 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs[i] !== 8'h00) begin n_err++; $display("FAIL reset_active[%0d]: got %h want 00", i, obs[i]); end
      n_checks++;
      if (obs8[i] !== 8'h00) begin n_err++; $display("FAIL reset_t8_active[%0d]: got %h want 00", i, obs8[i]); end
    end
    n_checks++;
    if (o_pend !== 1'b0 || o_err !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: pending=%b addr_err=%b want 0 0", o_pend, o_err);
    end
    bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_addr = 7'h05; bus.req1_addr = 7'h05;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_pointer: ready0=%b ready1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
  endtask

  task automatic test_single_write();
    bus.req0_valid = 1; bus.req0_addr = 7'h04; bus.req0_data = 8'h80;
    #1; predict();
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
    advance();
    bus.req0_valid = 0;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (obs[4] !== 8'h00 || o_pend !== 1'b1) begin
        n_err++; $display("FAIL single_wait: duty=%h pending=%b want 00 1", obs[4], o_pend);
      end
      advance();
    end
    commit_stb = 1; advance(); commit_stb = 0;
    n_checks++;
    if (obs[4] !== 8'h00 || o_pend !== 1'b1) begin
      n_err++; $display("FAIL single_commit_cycle: duty=%h pending=%b want 00 1", obs[4], o_pend);
    end
    advance();
    n_checks++;
    if (obs[4] !== 8'h80 || o_pend !== 1'b0) begin
      n_err++; $display("FAIL single_after: duty=%h pending=%b want 80 0", obs[4], o_pend);
    end
  endtask

  task automatic test_rr();
    logic [7:0] d0 [4];
    logic [7:0] d1 [4];
    int i0 = 0, i1 = 0;
    int order[$];
    bit g0, g1;
    do_reset();
    for (int k = 0; k < 4; k++) begin d0[k] = 8'($urandom); d1[k] = 8'($urandom); end
    for (int cyc = 0; cyc < 20 && (i0 < 4 || i1 < 4); cyc++) begin
      bus.req0_valid = (i0 < 4); bus.req0_addr = 7'h02; bus.req0_data = (i0 < 4) ? d0[i0] : 8'h00;
      bus.req1_valid = (i1 < 4); bus.req1_addr = 7'h02; bus.req1_data = (i1 < 4) ? d1[i1] : 8'h00;
      #1; predict();
      n_checks++;
      if (bus.req0_ready !== exp_r0 || bus.req1_ready !== exp_r1) begin
        n_err++; $display("FAIL rr_ready: got %b%b want %b%b", bus.req1_ready, bus.req0_ready, exp_r1, exp_r0);
      end
      g0 = bus.req0_ready; g1 = bus.req1_ready;
      advance();
      if (g0) begin order.push_back(0); i0++; end
      if (g1) begin order.push_back(1); i1++; end
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    n_checks++;
    if (order.size() != 8) begin n_err++; $display("FAIL rr_count: got %0d grants want 8", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      n_checks++;
      if (order[k] != k % 2) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 2); end
    end
    commit_stb = 1; advance(); commit_stb = 0; advance();
    n_checks++;
    if (obs[2] !== d1[3] || o_pend !== 1'b0) begin
      n_err++; $display("FAIL rr_commit: pwm_lo=%h pending=%b want %h 0", obs[2], o_pend, d1[3]);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] saved [5];
    for (int i = 0; i < 5; i++) saved[i] = obs[i];
    bus.req0_valid = 1; bus.req0_addr = 7'h05; bus.req0_data = 8'hAA;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL inv_ready: got %b want 1", bus.req0_ready); end
    advance();
    bus.req0_valid = 0;
    n_checks++;
    if (o_err !== 1'b1 || o_pend !== 1'b0) begin
      n_err++; $display("FAIL inv_pulse: addr_err=%b pending=%b want 1 0", o_err, o_pend);
    end
    advance();
    n_checks++;
    if (o_err !== 1'b0 || o_pend !== 1'b0) begin
      n_err++; $display("FAIL inv_after: addr_err=%b pending=%b want 0 0", o_err, o_pend);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs[i] !== saved[i]) begin n_err++; $display("FAIL inv_unchanged[%0d]: got %h want %h", i, obs[i], saved[i]); end
    end
  endtask

  task automatic test_timeout();
    bus8.req0_valid = 1; bus8.req0_addr = 7'h00; bus8.req0_data = 8'h0F;
    #1;
    n_checks++;
    if (bus8.req0_ready !== 1'b1) begin n_err++; $display("FAIL tmo_ready: got %b want 1", bus8.req0_ready); end
    advance();
    bus8.req0_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      n_checks++;
      if (obs8[0] !== ((k >= 10) ? 8'h0F : 8'h00) || t8_pend !== (k <= 9)) begin
        n_err++; $display("FAIL tmo_cycle%0d: out_lo=%h pending=%b want %h %b", k, obs8[0], t8_pend,
                          (k >= 10) ? 8'h0F : 8'h00, (k <= 9));
      end
      advance();
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] a, b, c, old0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    old0 = m_active[0];
    bus.req0_valid = 1; bus.req0_addr = 7'h01; bus.req0_data = a;
    #1; advance(); bus.req0_valid = 0;
    advance();
    bus.req1_valid = 1; bus.req1_addr = 7'h03; bus.req1_data = b; commit_stb = 1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL same_ready: got %b want 1", bus.req1_ready); end
    advance(); bus.req1_valid = 0; commit_stb = 0;
    bus.req0_valid = 1; bus.req0_addr = 7'h00; bus.req0_data = c;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0 || o_pend !== 1'b1) begin
      n_err++; $display("FAIL same_commit_block: ready0=%b pending=%b want 0 1", bus.req0_ready, o_pend);
    end
    advance();
    n_checks++;
    if (obs[1] !== a || obs[3] !== b || obs[0] !== old0 || o_pend !== 1'b0) begin
      n_err++; $display("FAIL same_values: out_hi=%h pwm_hi=%h out_lo=%h pend=%b want %h %h %h 0",
                        obs[1], obs[3], obs[0], o_pend, a, b, old0);
    end
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL same_retry_ready: got %b want 1", bus.req0_ready); end
    advance(); bus.req0_valid = 0;
    n_checks++;
    if (o_pend !== 1'b1) begin n_err++; $display("FAIL same_new_pending: got %b want 1", o_pend); end
    commit_stb = 1; advance(); commit_stb = 0; advance();
    n_checks++;
    if (obs[0] !== c) begin n_err++; $display("FAIL same_second_commit: out_lo=%h want %h", obs[0], c); end
  endtask

  task automatic test_reset_mid();
    bus.req0_valid = 1; bus.req0_addr = 7'h03; bus.req0_data = 8'hFF;
    #1; advance(); bus.req0_valid = 0;
    n_checks++;
    if (o_pend !== 1'b1) begin n_err++; $display("FAIL rmid_pending: got %b want 1", o_pend); end
    #2 rst_n = 0;
    #1; model_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs[i] !== 8'h00) begin n_err++; $display("FAIL rmid_active[%0d]: got %h want 00", i, obs[i]); end
    end
    n_checks++;
    if (o_pend !== 1'b0) begin n_err++; $display("FAIL rmid_pend: got %b want 0", o_pend); end
    @(posedge clk); #1; rst_n = 1;
    commit_stb = 1; advance(); commit_stb = 0; advance();
    n_checks++;
    if (obs[3] !== 8'h00 || o_pend !== 1'b0) begin
      n_err++; $display("FAIL rmid_after: pwm_hi=%h pending=%b want 00 0", obs[3], o_pend);
    end
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
        bus.req0_valid = 1;
        bus.req0_addr = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
        bus.req0_data = 8'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
        bus.req1_valid = 1;
        bus.req1_addr = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
        bus.req1_data = 8'($urandom);
      end
      commit_stb = ($urandom_range(0, 7) == 0);
      #1; predict();
      n_checks++;
      if (bus.req0_ready !== exp_r0 || bus.req1_ready !== exp_r1) begin
        n_err++; $display("FAIL rand_ready@%0d: got %b%b want %b%b", cyc, bus.req1_ready, bus.req0_ready, exp_r1, exp_r0);
      end
      g0 = bus.req0_ready; g1 = bus.req1_ready;
      advance();
      if (g0) bus.req0_valid = 0;
      if (g1) bus.req1_valid = 0;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (obs[i] !== m_active[i]) begin
          n_err++; $display("FAIL rand_active[%0d]@%0d: got %h want %h", i, cyc, obs[i], m_active[i]);
        end
      end
      n_checks++;
      if (o_pend !== (m_pend || m_commit) || o_err !== m_err) begin
        n_err++; $display("FAIL rand_flags@%0d: pending=%b addr_err=%b want %b %b", cyc, o_pend, o_err,
                          (m_pend || m_commit), m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_rr();
    test_invalid();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
